// File: rtl/uart_rx_deserializer_if.sv
// Receive-side status bundle between the UART deserializer and its controller.
//
// Handshake: rx_ready_o acts as a sticky valid. It rises when a byte is
// delivered into rx_data_o and stays high until the controller pulses
// rx_clear_i for one cycle (the acknowledge). rx_data_o holds its value
// across the acknowledge. A delivery in the same cycle as rx_clear_i wins.
// state_dbg mirrors the receiver FSM state for observation only.
`timescale 1ns/1ps
interface uart_rx_deserializer_if;
  logic [7:0] rx_data_o;
  logic       rx_ready_o;
  logic       rx_clear_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       rx_busy_o;
  logic [2:0] state_dbg;

  modport master (
    output rx_data_o, rx_ready_o, frame_err_o, overrun_o, rx_busy_o, state_dbg,
    input  rx_clear_i
  );

  modport slave (
    input  rx_data_o, rx_ready_o, frame_err_o, overrun_o, rx_busy_o, state_dbg,
    output rx_clear_i
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// Oversampling 8N1 UART receiver: 2-flop synchroniser, start-edge aligned
// sample ticks, three-sample majority vote around mid-bit, sticky ready,
// framing-error and overrun status for the controller.
`timescale 1ns/1ps
module uart_rx_deserializer #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   uart_rxd_i,
  uart_rx_deserializer_if.master bus
);

  localparam int DIV = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] SC_V0     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SC_V1     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SC_VOTE   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SC_LAST   = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic          sync1, rxd_s;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] sc;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          v0, v1;

  logic          run, tick, vote_tick, end_tick, maj;
  logic          shift_en, bit_inc, deliver, ferr_set;

  logic [7:0]    rx_data_q;
  logic          rx_ready_q, frame_err_q, overrun_q;

  // Counters only run while a frame is being timed; IDLE/BREAK hold them at
  // zero so the first tick lands DIV clocks after the detected start edge.
  assign run       = (state == S_START) || (state == S_DATA) || (state == S_STOP);
  assign tick      = run && (tick_cnt == TICK_LAST);
  assign vote_tick = tick && (sc == SC_VOTE);
  assign end_tick  = tick && (sc == SC_LAST);
  assign maj       = (v0 & v1) | (v0 & rxd_s) | (v1 & rxd_s);

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= uart_rxd_i;
      rxd_s <= sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // FSM next-state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    bit_inc   = 1'b0;
    deliver   = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxd_s) state_nxt = S_START;
      end
      S_START: begin
        if (vote_tick && maj) state_nxt = S_IDLE;
        else if (end_tick)    state_nxt = S_DATA;
      end
      S_DATA: begin
        if (vote_tick) shift_en = 1'b1;
        if (end_tick) begin
          bit_inc = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        // Leave at mid-stop-bit so a back-to-back start edge is not missed.
        if (vote_tick) begin
          if (maj) begin
            deliver   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxd_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tick divider, sample counter, bit counter, vote samples and shift register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt <= '0;
      sc       <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      v0       <= 1'b0;
      v1       <= 1'b0;
    end else if (!run) begin
      tick_cnt <= '0;
      sc       <= '0;
      bit_cnt  <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (tick) begin
        sc <= (sc == SC_LAST) ? '0 : sc + SW'(1);
        if (sc == SC_V0) v0 <= rxd_s;
        if (sc == SC_V1) v1 <= rxd_s;
      end
      if (shift_en) shreg   <= {maj, shreg[7:1]};
      if (bit_inc)  bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Sticky status flags; a delivery or framing error outranks a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_data_q   <= '0;
      rx_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (deliver) begin
        rx_data_q  <= shreg;
        rx_ready_q <= 1'b1;
      end else if (bus.rx_clear_i) begin
        rx_ready_q <= 1'b0;
      end

      if (deliver && rx_ready_q && !bus.rx_clear_i) overrun_q <= 1'b1;
      else if (bus.rx_clear_i)                      overrun_q <= 1'b0;

      if (ferr_set)            frame_err_q <= 1'b1;
      else if (bus.rx_clear_i) frame_err_q <= 1'b0;
    end
  end

  assign bus.rx_data_o   = rx_data_q;
  assign bus.rx_ready_o  = rx_ready_q;
  assign bus.frame_err_o = frame_err_q;
  assign bus.overrun_o   = overrun_q;
  assign bus.rx_busy_o   = (state != S_IDLE);
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed scenarios plus random frames with
// small baud offsets. A reference model updates the expected status tuple
// {data, ready, frame_err, overrun} from the receiver rules and queues every
// change; a monitor pops one entry each time the DUT's tuple changes.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

  // Reduced clock/baud ratio keeps runtime short; OVERSAMPLE stays 16.
  localparam int  TB_CLK_FREQ = 14_745_600;
  localparam int  TB_BAUD     = 115200;
  localparam int  TB_OS       = 16;
  localparam int  DIV         = (TB_CLK_FREQ + TB_BAUD * TB_OS / 2) / (TB_BAUD * TB_OS);
  localparam int  CPB         = DIV * TB_OS;
  localparam real CLK_NS      = 20.0;
  localparam real BIT_NS      = CPB * CLK_NS;
  // Stop-bit vote is tick number 9*OS + (OS/2+1) + 1 after the start edge is
  // seen; add 2 synchroniser clocks, 1 IDLE detect clock, registered delivery.
  localparam int  DELIVER_CYC = 3 + DIV * (9 * TB_OS + TB_OS / 2 + 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;

  uart_rx_deserializer_if bus();

  uart_rx_deserializer #(
    .CLK_FREQ  (TB_CLK_FREQ),
    .BAUD      (TB_BAUD),
    .OVERSAMPLE(TB_OS)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .uart_rxd_i(rxd),
    .bus       (bus)
  );

  // Clock and cycle counter.
  always #(CLK_NS / 2) clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];
  logic [10:0] last_obs = '0;
  int          ready_rise_cyc = -1;
  int          last_start_cyc = 0;

  // Reference model state.
  logic [7:0]  m_data = '0;
  logic        m_rdy = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
  logic [10:0] m_last = '0;

  task automatic model_push();
    logic [10:0] t;
    t = {m_data, m_rdy, m_ferr, m_ovr};
    if (t != m_last) begin
      exp_q.push_back(t);
      m_last = t;
    end
  endtask

  task automatic model_deliver(input logic [7:0] b, input logic with_clear);
    if (with_clear) begin
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end else if (m_rdy) begin
      m_ovr = 1'b1;
    end
    m_data = b;
    m_rdy  = 1'b1;
    model_push();
  endtask

  task automatic model_ferr();
    m_ferr = 1'b1;
    model_push();
  endtask

  task automatic model_clear();
    m_rdy  = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    model_push();
  endtask

  task automatic model_reset();
    m_data = '0;
    m_rdy  = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    model_push();
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: every change of the DUT status tuple consumes one expectation.
  task automatic monitor();
    logic [10:0] cur, exp;
    forever begin
      @(negedge clk);
      cur = {bus.rx_data_o, bus.rx_ready_o, bus.frame_err_o, bus.overrun_o};
      if (cur !== last_obs) begin
        if (cur[2] && !last_obs[2]) ready_rise_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got data=%h rdy=%b ferr=%b ovr=%b with nothing expected",
                   cur[10:3], cur[2], cur[1], cur[0]);
        end else begin
          exp = exp_q.pop_front();
          if (cur !== exp) begin
            errors++;
            $display("FAIL sb_tuple: got data=%h rdy=%b ferr=%b ovr=%b expected data=%h rdy=%b ferr=%b ovr=%b",
                     cur[10:3], cur[2], cur[1], cur[0], exp[10:3], exp[2], exp[1], exp[0]);
          end
        end
        last_obs = cur;
      end
    end
  endtask

  // Driver: one 8N1 frame starting one tick after a clock edge.
  task automatic send_frame(input logic [7:0] b, input real bit_ns,
                            input logic stop_val, input int gap_bits);
    @(posedge clk); #1;
    last_start_cyc = cyc;
    rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_ns);
    end
    rxd = stop_val;
    #(bit_ns);
    if (gap_bits > 0) begin
      rxd = 1'b1;
      #(bit_ns * gap_bits);
    end
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    bus.rx_clear_i = 1'b1;
    @(posedge clk); #1;
    bus.rx_clear_i = 1'b0;
  endtask

  // Time limit on the whole run.
  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Stimulus sequence.
  initial begin
    logic [7:0] rb;
    int         pm;
    real        bns;

    bus.rx_clear_i = 1'b0;
    fork
      monitor();
    join_none

    // Reset state.
    repeat (5) @(posedge clk); #1;
    chk("rst_data",  int'(bus.rx_data_o),   0);
    chk("rst_ready", int'(bus.rx_ready_o),  0);
    chk("rst_ferr",  int'(bus.frame_err_o), 0);
    chk("rst_ovr",   int'(bus.overrun_o),   0);
    chk("rst_busy",  int'(bus.rx_busy_o),   0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    // 1: plain frame 0x55 and delivery latency.
    model_deliver(8'h55, 1'b0);
    send_frame(8'h55, BIT_NS, 1'b1, 2);
    chk("t1_latency", ready_rise_cyc - last_start_cyc, DELIVER_CYC);
    chk("t1_data", int'(bus.rx_data_o), 'h55);
    chk("t1_ferr", int'(bus.frame_err_o), 0);
    chk("t1_ovr",  int'(bus.overrun_o), 0);
    chk("t1_busy", int'(bus.rx_busy_o), 0);
    model_clear();
    pulse_clear();

    // 2: short low glitch on idle line.
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (CPB / 4) @(posedge clk); #1;
    rxd = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("t2_busy_start", int'(bus.rx_busy_o), 1);
    repeat (CPB) @(posedge clk); #1;
    chk("t2_busy_idle", int'(bus.rx_busy_o), 0);
    chk("t2_ready", int'(bus.rx_ready_o), 0);
    chk("t2_ferr",  int'(bus.frame_err_o), 0);

    // 3: framing error, held-low line, then a good frame.
    model_ferr();
    send_frame(8'hA5, BIT_NS, 1'b0, 0);
    #(BIT_NS);
    chk("t3_break_busy", int'(bus.rx_busy_o), 1);
    chk("t3_ready", int'(bus.rx_ready_o), 0);
    chk("t3_ferr",  int'(bus.frame_err_o), 1);
    #(BIT_NS);
    rxd = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("t3_break_exit", int'(bus.rx_busy_o), 0);
    model_deliver(8'h3C, 1'b0);
    send_frame(8'h3C, BIT_NS, 1'b1, 1);
    chk("t3_data",       int'(bus.rx_data_o), 'h3C);
    chk("t3_ferr_stuck", int'(bus.frame_err_o), 1);
    model_clear();
    pulse_clear();
    chk("t3_ferr_clr", int'(bus.frame_err_o), 0);

    // 4: back-to-back frames cause overrun; clear keeps data.
    model_deliver(8'h11, 1'b0);
    send_frame(8'h11, BIT_NS, 1'b1, 0);
    model_deliver(8'h22, 1'b0);
    send_frame(8'h22, BIT_NS, 1'b1, 1);
    chk("t4_data",  int'(bus.rx_data_o), 'h22);
    chk("t4_ovr",   int'(bus.overrun_o), 1);
    chk("t4_ready", int'(bus.rx_ready_o), 1);
    model_clear();
    pulse_clear();
    chk("t4_clr_ready", int'(bus.rx_ready_o), 0);
    chk("t4_clr_ovr",   int'(bus.overrun_o), 0);
    chk("t4_clr_data",  int'(bus.rx_data_o), 'h22);

    // 5: clear coincides with delivery of a second byte.
    model_deliver(8'h44, 1'b0);
    send_frame(8'h44, BIT_NS, 1'b1, 1);
    model_deliver(8'h33, 1'b1);
    fork
      send_frame(8'h33, BIT_NS, 1'b1, 1);
      begin
        @(posedge clk);
        repeat (DELIVER_CYC - 1) @(posedge clk);
        #1 bus.rx_clear_i = 1'b1;
        @(posedge clk);
        #1 bus.rx_clear_i = 1'b0;
      end
    join
    chk("t5_ready", int'(bus.rx_ready_o), 1);
    chk("t5_ovr",   int'(bus.overrun_o), 0);
    chk("t5_data",  int'(bus.rx_data_o), 'h33);

    // 6: reset during data bit 4 of 0xC3, then a clean frame.
    @(posedge clk); #1;
    rxd = 1'b0;
    #(BIT_NS);
    rb = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      rxd = rb[i];
      #(BIT_NS);
    end
    rxd = rb[4];
    #(BIT_NS / 2);
    model_reset();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_data",  int'(bus.rx_data_o), 0);
    chk("t6_rst_ready", int'(bus.rx_ready_o), 0);
    chk("t6_rst_busy",  int'(bus.rx_busy_o), 0);
    rxd = 1'b1;
    repeat (10) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    model_deliver(8'h7E, 1'b0);
    send_frame(8'h7E, BIT_NS, 1'b1, 1);
    chk("t6_data", int'(bus.rx_data_o), 'h7E);
    model_clear();
    pulse_clear();

    // 7: +3% and -3% baud.
    model_deliver(8'h96, 1'b0);
    send_frame(8'h96, BIT_NS / 1.03, 1'b1, 2);
    chk("t7_fast_data", int'(bus.rx_data_o), 'h96);
    chk("t7_fast_ferr", int'(bus.frame_err_o), 0);
    model_clear();
    pulse_clear();
    model_deliver(8'h96, 1'b0);
    send_frame(8'h96, BIT_NS / 0.97, 1'b1, 2);
    chk("t7_slow_ready", int'(bus.rx_ready_o), 1);
    chk("t7_slow_ferr",  int'(bus.frame_err_o), 0);
    chk("t7_slow_ovr",   int'(bus.overrun_o), 0);

    // Random frames with up to +/-2% baud offset and random clears.
    for (int n = 0; n < 12; n++) begin
      rb  = 8'($urandom_range(0, 255));
      pm  = int'($urandom_range(0, 40)) - 20;
      bns = BIT_NS * 1000.0 / real'(1000 + pm);
      model_deliver(rb, 1'b0);
      send_frame(rb, bns, 1'b1, int'($urandom_range(1, 3)));
      if ($urandom_range(0, 1) == 1) begin
        model_clear();
        pulse_clear();
      end
    end

    // Drain and report.
    repeat (20) @(posedge clk); #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
